flow_ctrl_fsm_n: RTL
====================

Name: flow_ctrl_fsm_n

Overview:
Parametrised flow-control state machine for the N-channel FIFO fabric: one ingress FIFO plus N_CH egress FIFOs.
- Supervises FIFO status flags.
- Drives per-channel pausa/continuar with hysteresis.
- Owns the almost-full/almost-empty thresholds loaded during initialisation.
- Latches which FIFO overflowed.
- Successor to the fixed 4-channel flow-control FSM; sits between the FIFO bank and the ingress/egress arbiters.

Parameters:
N_CH, 4, number of egress channels; flag vectors are N_CH+1 wide, bit N_CH = ingress FIFO
FIFO_DEPTH, 8, entries per FIFO; thresholds range 0..FIFO_DEPTH
AF_DEFAULT, 6, almost-full threshold after reset
AE_DEFAULT, 2, almost-empty threshold after reset
TH_W (localparam), $clog2(FIFO_DEPTH+1), threshold width

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
enb  in  1  enable; when 0, state, thresholds and all outputs hold
iniciar  in  1  commit thresholds / leave ERROR
umbral_af_in  in  TH_W  candidate almost-full threshold
umbral_ae_in  in  TH_W  candidate almost-empty threshold
almost_full  in  N_CH+1  per-FIFO flags
full  in  N_CH+1  per-FIFO flags
almost_empty  in  N_CH+1  per-FIFO flags
empty  in  N_CH+1  per-FIFO flags
pausa  out  N_CH  stop writes into egress FIFO i
continuar  out  N_CH  resume writes into egress FIFO i
error_full  out  1  state == ERROR
idle  out  1  state == IDLE
error_ch  out  N_CH+1  sticky bitmap of FIFOs seen full
umbral_af  out  TH_W  committed almost-full threshold to the FIFOs
umbral_ae  out  TH_W  committed almost-empty threshold to the FIFOs
estado  out  3  state encoding: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4

Behaviour:
- Reset is synchronous, active-high, and wins over enb.
  - state=RESET; pausa=0, continuar=0, error_full=0, idle=0, error_ch=0.
  - umbral_af=AF_DEFAULT, umbral_ae=AE_DEFAULT.
- All outputs are registered: an input change is visible 1 cycle after the sampling edge. With enb=0 nothing updates.
- State transitions (evaluated only when enb=1):
  - RESET -> INIT: first enabled cycle with rst=0.
  - INIT -> IDLE: iniciar=1 with valid thresholds, i.e. umbral_ae_in < umbral_af_in and umbral_af_in <= FIFO_DEPTH. On that edge, umbral_af/umbral_ae load from the inputs.
  - INIT, invalid thresholds: iniciar is ignored, state stays INIT, thresholds unchanged.
  - IDLE -> ERROR: any bit of full set.
  - IDLE -> ACTIVE: otherwise, if any bit of empty is clear.
  - ACTIVE -> ERROR: any bit of full set.
  - ACTIVE -> IDLE: otherwise, if empty is all ones.
  - ERROR -> INIT: iniciar=1. error_ch clears on that same edge.
  - ERROR with iniciar=0: stays ERROR.
- error_ch: in IDLE or ACTIVE, bits OR in full every enabled cycle. Sticky until rst or exit from ERROR. full in RESET/INIT is not recorded and does not cause ERROR.
- Per-channel hysteresis, active only in ACTIVE, for i < N_CH:
  - pausa[i] sets when almost_full[i] or full[i].
  - pausa[i] clears only when almost_empty[i] or empty[i].
  - Both set and clear conditions true together: set wins.
  - continuar[i] = pausa[i] was 1 and clears this cycle. It is a 1-cycle pulse.
- Outside ACTIVE, pausa and continuar are forced to 0.
  - Exception: in ERROR, pausa is all ones (every channel stopped).
- The ingress FIFO bit N_CH only contributes to the error, idle and error_ch paths.
- Simultaneous full on several FIFOs: all corresponding error_ch bits set on the same edge.

Optional Feature:
ERR_CNT_EN
- Defined:
  - Adds output err_cnt [7:0]: a saturating count of IDLE/ACTIVE -> ERROR transitions.
  - Cleared only by rst; holds at 255.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package flow_ctrl_pkg holds:
  - state encoding constants (RESET..ERROR, 3-bit);
  - default thresholds AF_DEFAULT/AE_DEFAULT;
  - a threshold-validity function.
- One natural sub-module: flow_ctrl_ch_hyst.
  - Single-channel pausa/continuar hysteresis register.
  - Instantiated N_CH times via generate.
  - Inputs: active, error, almost_full, full, almost_empty, empty.

Test Plan:
- Reset then enable -> estado RESET, then INIT next cycle; umbral_af=6, umbral_ae=2; all other outputs 0.
- INIT, umbral_af_in=5, umbral_ae_in=5, iniciar=1 -> stays INIT, thresholds 6/2. Then af=7, ae=1, iniciar=1 -> IDLE next cycle, umbral_af=7, umbral_ae=1.
- IDLE, empty=5'b11110 -> ACTIVE. almost_full[0]=1 for 1 cycle -> pausa=4'b0001 held until almost_empty[0]=1, then pausa=0 with continuar=4'b0001 for exactly 1 cycle.
- ACTIVE, full=5'b10010 -> ERROR next cycle: error_full=1, error_ch=5'b10010, pausa=4'b1111. iniciar=1 -> INIT, error_ch=0.
- enb=0 while full=5'b00001 in ACTIVE -> no state change; once enb=1 -> ERROR 1 cycle later.
- rst asserted in ERROR with enb=0 -> next edge state RESET and all outputs at reset values. With ERR_CNT_EN: 3 error entries -> err_cnt=3; rst -> 0.

Source files
------------

// File: rtl/flow_ctrl_pkg.sv
// Shared types and helpers for the N-channel flow-control FSM.
// Holds the state encoding, default thresholds and threshold check.
package flow_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  localparam int AF_DEFAULT = 6;
  localparam int AE_DEFAULT = 2;

  function automatic logic th_ok(
    input int af,
    input int ae,
    input int depth
  );
    return (ae < af) && (af <= depth);
  endfunction

endpackage

// File: rtl/flow_ctrl_fsm_n_if.sv
// FIFO-status / flow-control bundle between the FIFO bank and the FSM.
// Optional err_cnt signal present only with ERR_CNT_EN.
interface flow_ctrl_fsm_n_if #(
  parameter int N_CH = 4,
  parameter int TH_W = 4
);
  logic            iniciar;
  logic [TH_W-1:0] umbral_af_in;
  logic [TH_W-1:0] umbral_ae_in;
  logic [N_CH:0]   almost_full;
  logic [N_CH:0]   full;
  logic [N_CH:0]   almost_empty;
  logic [N_CH:0]   empty;
  logic [N_CH-1:0] pausa;
  logic [N_CH-1:0] continuar;
  logic            error_full;
  logic            idle;
  logic [N_CH:0]   error_ch;
  logic [TH_W-1:0] umbral_af;
  logic [TH_W-1:0] umbral_ae;
  logic [2:0]      estado;
`ifdef ERR_CNT_EN
  logic [7:0]      err_cnt;
`endif

  modport master (
`ifdef ERR_CNT_EN
    input  err_cnt,
`endif
    output iniciar, umbral_af_in, umbral_ae_in,
    output almost_full, full, almost_empty, empty,
    input  pausa, continuar, error_full, idle,
    input  error_ch, umbral_af, umbral_ae, estado
  );

  modport slave (
`ifdef ERR_CNT_EN
    output err_cnt,
`endif
    input  iniciar, umbral_af_in, umbral_ae_in,
    input  almost_full, full, almost_empty, empty,
    output pausa, continuar, error_full, idle,
    output error_ch, umbral_af, umbral_ae, estado
  );

endinterface

// File: rtl/flow_ctrl_ch_hyst.sv
// Single-channel pausa/continuar hysteresis register.
// active/error are the state being entered on this edge.
module flow_ctrl_ch_hyst (
  input  logic clk,
  input  logic rst,
  input  logic enb,
  input  logic active,
  input  logic error,
  input  logic almost_full,
  input  logic full,
  input  logic almost_empty,
  input  logic empty,
  output logic pausa,
  output logic continuar
);

  logic set_c;
  logic clr_c;
  logic p_nx;
  logic c_nx;

  // set has priority over clear
  assign set_c = almost_full | full;
  assign clr_c = pausa & (almost_empty | empty) & ~set_c;
  assign p_nx  = error | (active & (set_c | (pausa & ~clr_c)));
  assign c_nx  = ~error & active & clr_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      pausa     <= 1'b0;
      continuar <= 1'b0;
    end else if (enb) begin
      pausa     <= p_nx;
      continuar <= c_nx;
    end
  end

endmodule

// File: rtl/flow_ctrl_fsm_n.sv
// N-channel flow-control FSM: thresholds, error capture, hysteresis.
// Optional saturating error counter enabled by ERR_CNT_EN.
module flow_ctrl_fsm_n
  import flow_ctrl_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_DEFAULT = flow_ctrl_pkg::AF_DEFAULT,
  parameter int AE_DEFAULT = flow_ctrl_pkg::AE_DEFAULT
) (
  input logic              clk,
  input logic              rst,
  input logic              enb,
  flow_ctrl_fsm_n_if.slave bus
);

  localparam int TH_W = $clog2(FIFO_DEPTH + 1);

  state_t          st;
  state_t          nx;
  logic            ok;
  logic            busy;
  logic [TH_W-1:0] af_q;
  logic [TH_W-1:0] ae_q;
  logic [N_CH:0]   ech_q;
  logic [N_CH-1:0] p;
  logic [N_CH-1:0] c;

  assign ok = th_ok(int'(bus.umbral_af_in),
                    int'(bus.umbral_ae_in),
                    FIFO_DEPTH);
  assign busy = (st == ST_IDLE) || (st == ST_ACTIVE);

  always_ff @(posedge clk) begin
    if (rst) st <= ST_RESET;
    else if (enb) st <= nx;
  end

  always_comb begin
    nx = st;
    unique case (st)
      ST_RESET: nx = ST_INIT;
      ST_INIT: if (bus.iniciar && ok) nx = ST_IDLE;
      ST_IDLE: begin
        if (|bus.full) nx = ST_ERROR;
        else if (!(&bus.empty)) nx = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (|bus.full) nx = ST_ERROR;
        else if (&bus.empty) nx = ST_IDLE;
      end
      ST_ERROR: if (bus.iniciar) nx = ST_INIT;
      default: nx = ST_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      af_q  <= TH_W'(AF_DEFAULT);
      ae_q  <= TH_W'(AE_DEFAULT);
      ech_q <= '0;
    end else if (enb) begin
      if (st == ST_INIT && bus.iniciar && ok) begin
        af_q <= bus.umbral_af_in;
        ae_q <= bus.umbral_ae_in;
      end
      if (st == ST_ERROR && bus.iniciar) ech_q <= '0;
      else if (busy) ech_q <= ech_q | bus.full;
    end
  end

`ifdef ERR_CNT_EN
  logic [7:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else if (enb && busy && nx == ST_ERROR && cnt_q != 8'hff)
      cnt_q <= cnt_q + 8'd1;
  end

  assign bus.err_cnt = cnt_q;
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    flow_ctrl_ch_hyst u_hyst (
      .clk          (clk),
      .rst          (rst),
      .enb          (enb),
      .active       (nx == ST_ACTIVE),
      .error        (nx == ST_ERROR),
      .almost_full  (bus.almost_full[i]),
      .full         (bus.full[i]),
      .almost_empty (bus.almost_empty[i]),
      .empty        (bus.empty[i]),
      .pausa        (p[i]),
      .continuar    (c[i])
    );
  end

  assign bus.pausa      = p;
  assign bus.continuar  = c;
  assign bus.error_full = (st == ST_ERROR);
  assign bus.idle       = (st == ST_IDLE);
  assign bus.error_ch   = ech_q;
  assign bus.umbral_af  = af_q;
  assign bus.umbral_ae  = ae_q;
  assign bus.estado     = st;

endmodule
